// File: rtl/alu_entry_sequencer.sv
// alu_entry_sequencer: button-stepped operand entry for the mini ALU.
// In: clk, rst_n, sw_value/sw_op, btn_next_n/btn_clear_n, alu_result.
// Out: alu_a/b/op, disp_value/blank, result_valid, state_leds.
module alu_entry_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sw_value,
  input  logic        sw_op,
  input  logic        btn_next_n,
  input  logic        btn_clear_n,
  input  logic [19:0] alu_result,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic        alu_op,
  output logic [19:0] disp_value,
  output logic        disp_blank,
  output logic        result_valid,
  output logic [3:0]  state_leds
);

  typedef enum logic [3:0] {
    ENTER_A = 4'b0001,
    ENTER_B = 4'b0010,
    COMPUTE = 4'b0100,
    SHOW    = 4'b1000
  } state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_CYCLES - 1);

  // bit 0 = next, bit 1 = clear
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    db_q, db_d, dbp_q;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] dcnt_q [2];
  logic [DW-1:0] dcnt_d [2];
  logic          next_p, clr_p;

  assign raw    = {btn_clear_n, btn_next_n};
  assign next_p = press_q[0];
  assign clr_p  = press_q[1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = '0;
      db_d[i]   = db_q[i];
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DEB_MAX) db_d[i] = sync2_q[i];
        else dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
    // falling edge of the debounced level, one cycle late
    press_d = dbp_q & ~db_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      db_q    <= '1;
      dbp_q   <= '1;
      press_q <= '0;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dbp_q   <= db_q;
      press_q <= press_d;
      for (int i = 0; i < 2; i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  state_t        state_q, state_d;
  logic [3:0]    a_q, a_d, b_q, b_d;
  logic          op_q, op_d;
  logic [19:0]   res_q, res_d;
  logic [19:0]   hold_q, hold_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          in_entry;
  logic          entering;

  assign in_entry = (state_q == ENTER_A) ||
                    (state_q == ENTER_B);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    bcnt_d  = '0;
    phase_d = 1'b0;
    if (clr_p) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = 1'b0;
      res_d   = '0;
    end else begin
      unique case (state_q)
        ENTER_A: if (next_p) begin
          a_d     = sw_value;
          state_d = ENTER_B;
        end
        ENTER_B: if (next_p) begin
          b_d     = sw_value;
          op_d    = sw_op;
          state_d = COMPUTE;
        end
        COMPUTE: begin
          res_d   = alu_result;
          state_d = SHOW;
        end
        SHOW: if (next_p) state_d = ENTER_A;
        default: state_d = ENTER_A;
      endcase
    end

    // a clear counts as a fresh entry so the display is visible at once
    entering = (state_d != state_q) || clr_p;
    if (in_entry && !entering) begin
      if (bcnt_q == BLK_MAX) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
        phase_d = phase_q;
      end
    end

    // COMPUTE shows whatever was on the display the cycle before
    if (in_entry) disp_value = {16'b0, sw_value};
    else if (state_q == SHOW) disp_value = res_q;
    else disp_value = hold_q;
    hold_d = disp_value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      res_q   <= '0;
      hold_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      hold_q  <= hold_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_op       = op_q;
  assign disp_blank   = in_entry & phase_q;
  assign result_valid = (state_q == SHOW);
  assign state_leds   = state_q;

endmodule

// File: doc/alu_entry_sequencer.md
Name: alu_entry_sequencer

Overview:
- Button-driven controller that sequences the mini ALU on the lab board.
- The user keys operand A, then operand B plus the operation, on the switches, stepping with a pushbutton. The block latches the operands and presents them to the ALU, captures the ALU result, and feeds the six-digit seven-segment display path with a value and a blank control.
- Sits between the board switches/keys and the existing ALU and seven-segment display modules.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz).
- BLINK_CYCLES, 25000000: half-period of the display blink during entry states.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- sw_value  input  4  operand value from the switches.
- sw_op  input  1  operation select from a switch.
- btn_next_n  input  1  raw "next" pushbutton; asynchronous, active-low, bouncy.
- btn_clear_n  input  1  raw "clear" pushbutton; asynchronous, active-low, bouncy.
- alu_result  input  20  decimal result returned from the ALU (combinational from alu_a/alu_b/alu_op).
- alu_a  output  4  registered operand A to the ALU.
- alu_b  output  4  registered operand B to the ALU.
- alu_op  output  1  registered operation to the ALU.
- disp_value  output  20  value for the seven-segment display module.
- disp_blank  output  1  1 = downstream forces all digits to 8'hFF.
- result_valid  output  1  high while a captured result is shown.
- state_leds  output  4  one-hot state indicator.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = ENTER_A; alu_a = 0, alu_b = 0, alu_op = 0, result_reg = 0.
  - result_valid = 0, disp_blank = 0, blink counter = 0, blink phase = 0.
  - Debounced button levels = 1 (released); synchronizers = 1.
  - Reset mid-operation discards everything.
- Button conditioning, per button:
  - 2-flop synchronizer, then debounce counter.
  - Counter resets whenever the synced level equals the debounced level. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced level.
  - A press generates a 1-cycle pulse on the debounced 1->0 transition. Holding a button never repeats. Release generates nothing.
- States and state_leds: ENTER_A=0001, ENTER_B=0010, COMPUTE=0100, SHOW=1000.
- ENTER_A:
  - disp_value = {16'b0, sw_value}, live.
  - next pulse: alu_a <= sw_value; go to ENTER_B.
- ENTER_B:
  - disp_value = {16'b0, sw_value}, live.
  - next pulse: alu_b <= sw_value and alu_op <= sw_op in the same edge; go to COMPUTE.
- COMPUTE:
  - Exactly 1 cycle. result_reg <= alu_result; go to SHOW.
  - disp_value holds its previous value.
- SHOW:
  - disp_value = result_reg; result_valid = 1; disp_blank = 0 (steady).
  - next pulse: go to ENTER_A. alu_a/alu_b/alu_op keep their values; result_valid drops on the transition.
- Latency:
  - Press pulse in cycle N (in ENTER_B) -> COMPUTE in N+1 -> SHOW and result_valid in N+2.
  - Raw press to pulse = 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Clear:
  - clear pulse in any state: go to ENTER_A; alu_a = alu_b = alu_op = 0; result_reg = 0; result_valid = 0.
  - Clear has priority over a simultaneous next pulse.
- Blink:
  - In ENTER_A/ENTER_B a counter runs 0..BLINK_CYCLES-1 and toggles the phase on wrap. disp_blank = phase.
  - Counter and phase reset to 0 on every state entry, so the display is visible immediately after each step.
  - In COMPUTE/SHOW, disp_blank = 0 and the counter is held at 0.
- Switch changes outside a latching edge have no effect on alu_a, alu_b or alu_op.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8; bench ALU stub: op 0 -> a+b, op 1 -> a*b):
- Reset, no buttons -> state_leds=0001, alu_a=0, result_valid=0, disp_value follows sw_value=9 -> 9.
- sw_value=7, press next; sw_value=5, sw_op=1, press next -> alu_a=7, alu_b=5, alu_op=1; result_valid 2 cycles after the second pulse; disp_value=35; state_leds=1000.
- Bounce: btn_next_n toggles every 2 cycles for 20 cycles, then held low -> exactly one pulse, 7 cycles after it settles; one state advance only.
- Hold btn_next_n low for 100 cycles in ENTER_A -> single advance to ENTER_B, no further steps.
- In ENTER_A, idle 32 cycles -> disp_blank pattern 8 low / 8 high repeating. Press next -> disp_blank=0 on ENTER_B entry.
- Next and clear pulses in the same cycle while in SHOW -> ENTER_A with alu_a=0, result_valid=0. Assert rst_n low mid-debounce -> all outputs at reset values immediately.
